// File: rtl/simmem_row_model.sv
// -----------------------------------------------------------------------------
// simmem_row_model
//
// Multi-bank DRAM row-buffer timing model. Each accepted request is decoded
// into bank/row/column, charged a row-hit, activation or
// precharge+activation cost against that bank's open-row state, and its
// identifier is returned on the completion port once the charged number of
// cycles has elapsed. Completions from banks waiting at the same time are
// arbitrated with fixed priority (lowest bank index first).
//
// Ports:
//   clk_i          clock
//   rst_ni         synchronous active-low reset
//   req_valid_i    request valid
//   req_ready_o    request ready (decoded bank is idle)
//   req_addr_i     byte address {row, bank, column}
//   req_id_i       request identifier
//   done_valid_o   completion valid
//   done_ready_i   completion accepted
//   done_id_o      identifier of the completed request
//   done_delay_o   cycles charged to that request
//
// Configuration macro:
//   SIMMEM_ROW_MODEL_CLOSED_PAGE_EN  closed-page policy: every access pays
//                                    precharge+activation+hit and the row is
//                                    closed when the completion is accepted.
//                                    Undefined: open-page policy.
// -----------------------------------------------------------------------------
module simmem_row_model #(
    parameter int NumBanks          = 4,
    parameter int AddrWidth         = 16,
    parameter int RowBufferLenWidth = 8,
    parameter int IdWidth           = 2,
    parameter int RowHitCost        = 10,
    parameter int PrechargeCost     = 50,
    parameter int ActivationCost    = 45,
    parameter int DelayWidth        = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [AddrWidth-1:0]  req_addr_i,
    input  logic [IdWidth-1:0]    req_id_i,
    output logic                  done_valid_o,
    input  logic                  done_ready_i,
    output logic [IdWidth-1:0]    done_id_o,
    output logic [DelayWidth-1:0] done_delay_o
);

    localparam int BankSelBits = $clog2(NumBanks);
    localparam int BankIdxW    = (BankSelBits > 0) ? BankSelBits : 1;
    localparam int RowWidth    = AddrWidth - RowBufferLenWidth - BankSelBits;

    localparam logic [DelayWidth-1:0] HitCost  = DelayWidth'(RowHitCost);
    localparam logic [DelayWidth-1:0] OpenCost = DelayWidth'(ActivationCost + RowHitCost);
    localparam logic [DelayWidth-1:0] FullCost =
        DelayWidth'(PrechargeCost + ActivationCost + RowHitCost);

    if (PrechargeCost + ActivationCost + RowHitCost >= (1 << DelayWidth)) begin : gen_chk_delay
        $error("simmem_row_model: worst-case cost does not fit in DelayWidth");
    end
    if (RowHitCost < 3) begin : gen_chk_hit
        $error("simmem_row_model: RowHitCost must be at least 3");
    end
    if (NumBanks < 1 || (NumBanks & (NumBanks - 1)) != 0) begin : gen_chk_banks
        $error("simmem_row_model: NumBanks must be a power of two");
    end

    typedef enum logic [1:0] {
        BankIdle = 2'd0,
        BankBusy = 2'd1,
        BankDone = 2'd2
    } bank_state_e;

    // Per-bank state
    bank_state_e             state_q         [NumBanks];
    bank_state_e             state_d         [NumBanks];
    logic [NumBanks-1:0]     open_row_valid_q, open_row_valid_d;
    logic [RowWidth-1:0]     open_row_q      [NumBanks];
    logic [RowWidth-1:0]     open_row_d      [NumBanks];
    logic [IdWidth-1:0]      id_q            [NumBanks];
    logic [IdWidth-1:0]      id_d            [NumBanks];
    logic [DelayWidth-1:0]   delay_q         [NumBanks];
    logic [DelayWidth-1:0]   delay_d         [NumBanks];
    logic [DelayWidth-1:0]   cnt_q           [NumBanks];
    logic [DelayWidth-1:0]   cnt_d           [NumBanks];

    // Request decode
    logic [BankIdxW-1:0]   req_bank;
    logic [RowWidth-1:0]   req_row;
    logic [DelayWidth-1:0] req_cost;
    logic                  req_fire;
    logic                  unused_col;

    // Column bits only select a byte within the row buffer; they never affect timing.
    assign unused_col = ^req_addr_i[RowBufferLenWidth-1:0];
    assign req_row    = req_addr_i[AddrWidth-1 -: RowWidth];

    always_comb begin
        req_bank = '0;
        if (NumBanks > 1) begin
            req_bank = req_addr_i[RowBufferLenWidth +: BankIdxW];
        end
    end

    assign req_ready_o = (state_q[req_bank] == BankIdle);
    assign req_fire    = req_valid_i && req_ready_o;

    always_comb begin
`ifdef SIMMEM_ROW_MODEL_CLOSED_PAGE_EN
        req_cost = FullCost;
`else
        if (!open_row_valid_q[req_bank]) begin
            req_cost = OpenCost;
        end else if (open_row_q[req_bank] == req_row) begin
            req_cost = HitCost;
        end else begin
            req_cost = FullCost;
        end
`endif
    end

    // Completion arbitration: scanning downwards leaves the lowest DONE bank.
    logic                grant_valid;
    logic [BankIdxW-1:0] grant_bank;
    logic                done_fire;

    always_comb begin
        grant_valid = 1'b0;
        grant_bank  = '0;
        for (int i = NumBanks - 1; i >= 0; i--) begin
            if (state_q[i] == BankDone) begin
                grant_valid = 1'b1;
                grant_bank  = BankIdxW'(i);
            end
        end
    end

    assign done_fire    = grant_valid && done_ready_i;
    assign done_valid_o = grant_valid;
    assign done_id_o    = grant_valid ? id_q[grant_bank]    : '0;
    assign done_delay_o = grant_valid ? delay_q[grant_bank] : '0;

    // Bank FSMs: next state and payload
    always_comb begin
        // NOTE: every _d signal starts from its _q value so no path leaves it
        // unassigned; a missing default here would infer a latch.
        open_row_valid_d = open_row_valid_q;
        for (int i = 0; i < NumBanks; i++) begin
            state_d[i]    = state_q[i];
            open_row_d[i] = open_row_q[i];
            id_d[i]       = id_q[i];
            delay_d[i]    = delay_q[i];
            cnt_d[i]      = cnt_q[i];

            case (state_q[i])
                BankIdle: begin
                    if (req_fire && req_bank == BankIdxW'(i)) begin
                        state_d[i]          = BankBusy;
                        cnt_d[i]            = req_cost;
                        delay_d[i]          = req_cost;
                        id_d[i]             = req_id_i;
                        open_row_d[i]       = req_row;
                        open_row_valid_d[i] = 1'b1;
                    end
                end
                BankBusy: begin
                    // Loaded with C at the accept edge, so reaching 1 lands DONE at edge T+C.
                    if (cnt_q[i] == DelayWidth'(1)) begin
                        state_d[i] = BankDone;
                    end else begin
                        cnt_d[i] = cnt_q[i] - DelayWidth'(1);
                    end
                end
                BankDone: begin
                    if (done_fire && grant_bank == BankIdxW'(i)) begin
                        state_d[i] = BankIdle;
`ifdef SIMMEM_ROW_MODEL_CLOSED_PAGE_EN
                        open_row_valid_d[i] = 1'b0;
`endif
                    end
                end
                default: state_d[i] = BankIdle;
            endcase
        end
    end

    // Control state: reset closes every row and drops outstanding requests.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its _d value from before the edge, independent of order.
        if (!rst_ni) begin
            for (int i = 0; i < NumBanks; i++) begin
                state_q[i] <= BankIdle;
            end
            open_row_valid_q <= '0;
        end else begin
            state_q          <= state_d;
            open_row_valid_q <= open_row_valid_d;
        end
    end

    // NOTE: payload registers are deliberately not reset; they are only read
    // when the owning bank's state or open_row_valid qualifies them.
    always_ff @(posedge clk_i) begin
        open_row_q <= open_row_d;
        id_q       <= id_d;
        delay_q    <= delay_d;
        cnt_q      <= cnt_d;
    end

endmodule

// File: tb/tb_simmem_row_model.sv
// -----------------------------------------------------------------------------
// tb_simmem_row_model
//
// Directed self-checking bench for simmem_row_model with default parameters.
// Bank bits are addr[9:8], row bits addr[15:10]. Inputs change and outputs
// are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_simmem_row_model;

`ifdef SIMMEM_ROW_MODEL_CLOSED_PAGE_EN
    localparam int CostOpen = 105;
    localparam int CostHit  = 105;
`else
    localparam int CostOpen = 55;
    localparam int CostHit  = 10;
`endif
    localparam int CostMiss = 105;
    localparam int WaitLimit = 300;

    logic       clk_i;
    logic       rst_ni;
    logic       req_valid_i;
    logic       req_ready_o;
    logic [15:0] req_addr_i;
    logic [1:0] req_id_i;
    logic       done_valid_o;
    logic       done_ready_i;
    logic [1:0] done_id_o;
    logic [7:0] done_delay_o;

    int n_total = 0;
    int n_pass  = 0;

    simmem_row_model dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_id_i    (req_id_i),
        .done_valid_o(done_valid_o),
        .done_ready_i(done_ready_i),
        .done_id_o   (done_id_o),
        .done_delay_o(done_delay_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present one request for one edge; the caller checks readiness first.
    task automatic send(input logic [15:0] addr, input logic [1:0] id);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        req_id_i    = id;
        step();
        req_valid_i = 1'b0;
    endtask

    // Steps until done_valid_o is seen; returns the number of edges waited.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done_valid_o !== 1'b1 && cycles < WaitLimit) begin
            step();
            cycles++;
        end
    endtask

    task automatic handshake();
        done_ready_i = 1'b1;
        step();
        done_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        done_ready_i = 1'b0;
        req_addr_i   = '0;
        req_id_i     = '0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (done_valid_o !== 1'b0) $display("FAIL reset_done_valid: got %b expected 0", done_valid_o);
        else n_pass++;
        n_total++;
        if (done_id_o !== 2'd0) $display("FAIL reset_done_id: got %0d expected 0", done_id_o);
        else n_pass++;
        n_total++;
        if (done_delay_o !== 8'd0) $display("FAIL reset_done_delay: got %0d expected 0", done_delay_o);
        else n_pass++;
        n_total++;
        if (req_ready_o !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", req_ready_o);
        else n_pass++;
    endtask

    task automatic test_row_policy();
        int cycles;
        // First access to a closed row
        send(16'h0000, 2'd1);
        wait_done(cycles);
        n_total++;
        if (cycles != CostOpen) $display("FAIL open_latency: got %0d expected %0d", cycles, CostOpen);
        else n_pass++;
        n_total++;
        if (done_id_o !== 2'd1) $display("FAIL open_id: got %0d expected 1", done_id_o);
        else n_pass++;
        n_total++;
        if (done_delay_o !== 8'(CostOpen)) $display("FAIL open_delay: got %0d expected %0d", done_delay_o, CostOpen);
        else n_pass++;
        handshake();
        // Same row, different column
        send(16'h0004, 2'd2);
        wait_done(cycles);
        n_total++;
        if (cycles != CostHit) $display("FAIL hit_latency: got %0d expected %0d", cycles, CostHit);
        else n_pass++;
        n_total++;
        if (done_id_o !== 2'd2 || done_delay_o !== 8'(CostHit))
            $display("FAIL hit_completion: got id %0d delay %0d expected id 2 delay %0d", done_id_o, done_delay_o, CostHit);
        else n_pass++;
        handshake();
        // Bank 0, row 1: conflicts with the open row 0
        send(16'h0400, 2'd3);
        wait_done(cycles);
        n_total++;
        if (cycles != CostMiss || done_id_o !== 2'd3 || done_delay_o !== 8'(CostMiss))
            $display("FAIL miss_completion: got lat %0d id %0d delay %0d expected lat %0d id 3 delay %0d",
                     cycles, done_id_o, done_delay_o, CostMiss, CostMiss);
        else n_pass++;
        handshake();
        n_total++;
        if (done_valid_o !== 1'b0) $display("FAIL idle_after_handshake: got %b expected 0", done_valid_o);
        else n_pass++;
    endtask

    task automatic test_arbitration();
        int  cycles;
        bit  held_ok;
        do_reset();
        send(16'h0000, 2'd0);
        req_addr_i = 16'h0100;
        n_total++;
        if (req_ready_o !== 1'b1) $display("FAIL b2b_ready_bank1: got %b expected 1", req_ready_o);
        else n_pass++;
        send(16'h0100, 2'd1);
        wait_done(cycles);
        n_total++;
        if (done_id_o !== 2'd0 || done_delay_o !== 8'(CostOpen))
            $display("FAIL arb_first: got id %0d delay %0d expected id 0 delay %0d", done_id_o, done_delay_o, CostOpen);
        else n_pass++;
        // Bank 1 enters DONE during this window; bank 0 must keep the output.
        held_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done_valid_o !== 1'b1 || done_id_o !== 2'd0) held_ok = 1'b0;
        end
        n_total++;
        if (!held_ok) $display("FAIL arb_hold: got id %0d valid %b expected id 0 valid 1", done_id_o, done_valid_o);
        else n_pass++;
        handshake();
        n_total++;
        if (done_valid_o !== 1'b1 || done_id_o !== 2'd1 || done_delay_o !== 8'(CostOpen))
            $display("FAIL arb_second: got valid %b id %0d delay %0d expected valid 1 id 1 delay %0d",
                     done_valid_o, done_id_o, done_delay_o, CostOpen);
        else n_pass++;
        handshake();
        n_total++;
        if (done_valid_o !== 1'b0) $display("FAIL arb_drained: got %b expected 0", done_valid_o);
        else n_pass++;
    endtask

    task automatic test_busy_block();
        int cycles;
        bit blocked_ok;
        do_reset();
        send(16'h0000, 2'd2);
        req_valid_i = 1'b1;
        req_addr_i  = 16'h0000;
        n_total++;
        if (req_ready_o !== 1'b0) $display("FAIL busy_blocks: got %b expected 0", req_ready_o);
        else n_pass++;
        req_addr_i = 16'h0200;
        req_id_i   = 2'd3;
        n_total++;
        if (req_ready_o !== 1'b1) $display("FAIL other_bank_ready: got %b expected 1", req_ready_o);
        else n_pass++;
        step();                       // bank 2 accepted
        req_addr_i = 16'h0000;
        req_id_i   = 2'd1;
        blocked_ok = 1'b1;
        cycles     = 0;
        while (done_valid_o !== 1'b1 && cycles < WaitLimit) begin
            if (req_ready_o !== 1'b0) blocked_ok = 1'b0;
            step();
            cycles++;
        end
        n_total++;
        if (!blocked_ok || done_id_o !== 2'd2)
            $display("FAIL busy_until_done: got blocked %b id %0d expected blocked 1 id 2", blocked_ok, done_id_o);
        else n_pass++;
        // Handshake cycle on bank 0 with a request to bank 0 still pending.
        n_total++;
        if (req_ready_o !== 1'b0) $display("FAIL ready_during_handshake: got %b expected 0", req_ready_o);
        else n_pass++;
        done_ready_i = 1'b1;
        step();
        done_ready_i = 1'b0;
        n_total++;
        if (req_ready_o !== 1'b1 || done_id_o !== 2'd3)
            $display("FAIL after_handshake: got ready %b id %0d expected ready 1 id 3", req_ready_o, done_id_o);
        else n_pass++;
        step();                       // bank 0 accepts the same row again
        req_valid_i = 1'b0;
        handshake();                  // retire bank 2
        wait_done(cycles);
        n_total++;
        if (done_id_o !== 2'd1 || done_delay_o !== 8'(CostHit))
            $display("FAIL reaccept: got id %0d delay %0d expected id 1 delay %0d", done_id_o, done_delay_o, CostHit);
        else n_pass++;
        handshake();
    endtask

    task automatic test_reset_mid();
        int cycles;
        bit quiet;
        do_reset();
        send(16'h0000, 2'd1);
        for (int i = 0; i < 10; i++) step();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (done_valid_o !== 1'b0) quiet = 1'b0;
            step();
        end
        n_total++;
        if (!quiet || req_ready_o !== 1'b1)
            $display("FAIL reset_discards: got quiet %b ready %b expected quiet 1 ready 1", quiet, req_ready_o);
        else n_pass++;
        send(16'h0000, 2'd2);
        wait_done(cycles);
        n_total++;
        if (cycles != CostOpen || done_id_o !== 2'd2 || done_delay_o !== 8'(CostOpen))
            $display("FAIL reset_closes_row: got lat %0d id %0d delay %0d expected lat %0d id 2 delay %0d",
                     cycles, done_id_o, done_delay_o, CostOpen, CostOpen);
        else n_pass++;
        handshake();
    endtask

    initial begin
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        done_ready_i = 1'b0;
        req_addr_i   = '0;
        req_id_i     = '0;
        test_reset();
        test_row_policy();
        test_arbitration();
        test_busy_block();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/simmem_row_model.md
# simmem_row_model

Parametrised multi-bank DRAM row-buffer timing model for the simulated memory controller. It accepts one address request per cycle, decodes it into bank, row and column, and charges a row-hit, activation or precharge+activation cost against that bank's open-row state. It returns the request identifier after the charged number of cycles. It generalises the single fixed-cost memory timing parameters (row hit 10, precharge 50, activation 45) to N independent banks with per-bank occupancy and completion arbitration. It sits between the address-request arbiter and the response banks, which use its completions to release delayed responses.

## Interface
Parameters:
- NumBanks, 4: independent banks, power of two, ≥1.
- AddrWidth, 16: request address width.
- RowBufferLenWidth, 8: column bits; row buffer holds 2^RowBufferLenWidth bytes.
- IdWidth, 2: request identifier width.
- RowHitCost, 10: cycles for an open-row hit; must be ≥3.
- PrechargeCost, 50: cycles to close a row.
- ActivationCost, 45: cycles to open a row.
- DelayWidth, 8: width of the reported delay. Elaboration assertion: PrechargeCost+ActivationCost+RowHitCost < 2^DelayWidth.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: reset. Synchronous and active-low, sampled on the rising edge of clk_i.
- req_valid_i, in, 1: request valid.
- req_ready_o, out, 1: request ready.
- req_addr_i, in, AddrWidth: byte address.
- req_id_i, in, IdWidth: request identifier.
- done_valid_o, out, 1: completion valid.
- done_ready_i, in, 1: completion accepted.
- done_id_o, out, IdWidth: identifier of the completed request.
- done_delay_o, out, DelayWidth: cycles charged to that request.

## Operation
- Address decode: column = addr[RowBufferLenWidth-1:0]; bank = addr[RowBufferLenWidth +: log2(NumBanks)]; row = all remaining upper bits. With NumBanks=1 there are no bank bits.
- Per-bank state: open_row_valid, open_row, id, delay, down-counter, FSM.
- Bank FSM states:
  - IDLE: no request outstanding; the open row may be open or closed.
  - BUSY: the counter is running.
  - DONE: the completion is waiting for handshake.
- IDLE→BUSY: on handshake req_valid_i && req_ready_o to this bank.
- BUSY→DONE: when the counter reaches 1.
- DONE→IDLE: when this bank is granted and done_ready_i is high.
- Cost on accept:
  - Row closed: ActivationCost+RowHitCost.
  - Same row open: RowHitCost.
  - Different row open: PrechargeCost+ActivationCost+RowHitCost.
- On accept, open_row is updated to the request row and open_row_valid is set to 1.
- req_ready_o is combinational: it is 1 iff the bank decoded from req_addr_i is in IDLE. A busy bank never blocks requests to other banks.
- Completion arbitration: fixed priority, lowest bank index in DONE wins.
- The output mux is driven from the winning bank's registers. Non-winning DONE banks hold their state until granted.
- done_id_o and done_delay_o are stable while done_valid_o=1 and done_ready_i=0, unless a lower-index bank enters DONE. That lower bank then pre-empts the output; no data is lost.
- Arithmetic: costs are computed at DelayWidth bits; overflow is excluded by the elaboration assertion.

## Timing
- Reset values (after any cycle with rst_ni=0):
  - All banks IDLE, open_row_valid=0.
  - done_valid_o=0, done_id_o=0, done_delay_o=0.
  - req_ready_o=1.
- Latency: a request accepted at edge T with cost C makes its bank enter DONE at edge T+C. done_valid_o is therefore high in the cycle following edge T+C, provided the bank wins arbitration.
- Throughput: a bank can accept its next request in the cycle after its DONE handshake. Different banks accept requests back-to-back, one per cycle.
- Simultaneous DONE handshake and a new request to the same bank in the same cycle: the request is not accepted (req_ready_o=0 that cycle).
- Reset mid-operation: all outstanding requests are discarded without completions, and all rows are closed.

## Configuration
- SIMMEM_ROW_MODEL_CLOSED_PAGE_EN defined:
  - Closed-page policy: every access costs ActivationCost+RowHitCost+PrechargeCost, with the precharge charged to that access.
  - open_row_valid is forced to 0 on each DONE→IDLE transition.
- Undefined: open-page policy as described in Operation.

## Test plan
All scenarios use default parameters. Bank bits are [9:8]; row bits are [15:10].
- Reset, then addr 0x0000 id 1 accepted at edge T → done_valid_o rises after edge T+55, done_id_o=1, done_delay_o=55.
- Then addr 0x0004 id 2 (same row) → done_delay_o=10, completion 10 cycles after accept.
- Then addr 0x0400 id 3 (bank 0, row 1) → done_delay_o=105.
- Addr 0x0000 and addr 0x0100 accepted on consecutive cycles with done_ready_i=0 → bank 0 is presented first (delay 55). Bank 1 is held; it appears on the cycle after bank 0's handshake.
- Second request to bank 0 while it is BUSY → req_ready_o=0 until the cycle after its DONE handshake. A concurrent request to bank 2 is accepted immediately.
- rst_ni low for one cycle while bank 0 is BUSY → no completion is produced. A subsequent 0x0000 access costs 55. With SIMMEM_ROW_MODEL_CLOSED_PAGE_EN, every access above costs 105.
